// File: rtl/apb8_bridge_pkg.sv
// Shared types and helpers for the 64-bit host to 8-bit APB bridge.
package apb8_bridge_pkg;

    // Bridge sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // Read size encodings on req_size.
    typedef enum logic [1:0] {
        SIZE_1B = 2'd0,
        SIZE_2B = 2'd1,
        SIZE_4B = 2'd2,
        SIZE_8B = 2'd3
    } size_t;

    localparam int LANES = 8;

    // Number of byte lanes touched by a read of the given size.
    function automatic logic [3:0] size_lanes(input size_t size);
        logic [3:0] n;
        case (size)
            SIZE_1B: n = 4'd1;
            SIZE_2B: n = 4'd2;
            SIZE_4B: n = 4'd4;
            default: n = 4'd8;
        endcase
        return n;
    endfunction

    // True when a read starting at lane would run past lane 7.
    function automatic logic read_overflow(input logic [2:0] lane, input size_t size);
        return ({1'b0, lane} + size_lanes(size)) > 4'd8;
    endfunction

    // Consecutive-lane mask for a read; lanes beyond 7 fall off the top.
    function automatic logic [7:0] read_mask(input logic [2:0] lane, input size_t size);
        logic [15:0] m;
        m = (16'd1 << size_lanes(size)) - 16'd1;
        m = m << lane;
        return m[7:0];
    endfunction

endpackage

// File: rtl/apb8_lane_pick.sv
// Lowest-set-bit picker: returns the index of the lowest pending byte lane.
module apb8_lane_pick
    import apb8_bridge_pkg::*;
(
    input  logic [7:0] i_mask,
    output logic [2:0] o_lane,
    output logic       o_any
);

    // Scan from the top so the lowest set bit wins.
    always_comb begin
        o_lane = 3'd0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (i_mask[i]) begin
                o_lane = 3'(i);
            end
        end
        o_any = |i_mask;
    end

endmodule

// File: rtl/apb8_host_bridge.sv
// 64-bit host request/response port to an 8-bit APB master. Each enabled
// byte lane becomes one APB transfer, lowest lane first.
//
// Handshakes: a request transfers on a clock edge where req_valid and
// req_ready are both 1; a response transfers on an edge where rsp_valid and
// rsp_ready are both 1. rsp_valid, rsp_rdata and rsp_err are held stable
// until that edge. The APB side is a plain SETUP/ACCESS master that waits
// for pready, bounded by TIMEOUT_CYCLES.
module apb8_host_bridge
    import apb8_bridge_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ADDR_W         = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic [63:0]       req_wdata,
    input  logic [7:0]        req_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [63:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [7:0]        pwdata,
    input  logic              pready,
    input  logic              pslverr,
    input  logic [7:0]        prdata,
    output logic [1:0]        dbg_state
);

    // Last ACCESS cycle index before a byte is forced to error.
    localparam logic [9:0] TO_LAST = 10'(TIMEOUT_CYCLES - 1);

    state_t            r_state;
    logic [7:0]        r_mask;
    logic [2:0]        r_lane;
    logic [ADDR_W-4:0] r_base;
    logic [63:0]       r_wdata;
    logic              r_write;
    logic [9:0]        r_cnt;
    logic              r_psel;
    logic              r_penable;
    logic              r_pwrite;
    logic [ADDR_W-1:0] r_paddr;
    logic [7:0]        r_pwdata;
    logic              r_rsp_valid;
    logic [63:0]       r_rsp_rdata;
    logic              r_rsp_err;

    logic [7:0]        w_new_mask;
    logic [7:0]        w_mask_rest;
    logic [7:0]        w_pick_in;
    logic [2:0]        w_pick_lane;
    logic              w_pick_any;
    logic              w_rd_ovf;

    // Lane mask of an incoming request and of the lanes still pending.
    always_comb begin
        w_new_mask  = req_write ? req_wstrb : read_mask(req_addr[2:0], size_t'(req_size));
        w_rd_ovf    = !req_write && read_overflow(req_addr[2:0], size_t'(req_size));
        w_mask_rest = r_mask & ~(8'd1 << r_lane);
        w_pick_in   = (r_state == ST_IDLE) ? w_new_mask : w_mask_rest;
    end

    apb8_lane_pick u_lane_pick (
        .i_mask (w_pick_in),
        .o_lane (w_pick_lane),
        .o_any  (w_pick_any)
    );

    // Bridge FSM with registered APB and response outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_mask      <= '0;
            r_lane      <= '0;
            r_base      <= '0;
            r_wdata     <= '0;
            r_write     <= 1'b0;
            r_cnt       <= '0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_write     <= req_write;
                        r_base      <= req_addr[ADDR_W-1:3];
                        r_wdata     <= req_wdata;
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b0;
                        if (w_rd_ovf) begin
                            r_rsp_err   <= 1'b1;
                            r_rsp_valid <= 1'b1;
                            r_state     <= ST_RESP;
                        end else if (!w_pick_any) begin
                            r_rsp_valid <= 1'b1;
                            r_state     <= ST_RESP;
                        end else begin
                            r_mask    <= w_new_mask;
                            r_lane    <= w_pick_lane;
                            r_psel    <= 1'b1;
                            r_penable <= 1'b0;
                            r_pwrite  <= req_write;
                            r_paddr   <= {req_addr[ADDR_W-1:3], w_pick_lane};
                            r_pwdata  <= req_wdata[{w_pick_lane, 3'b000} +: 8];
                            r_state   <= ST_SETUP;
                        end
                    end
                end
                ST_SETUP: begin
                    r_penable <= 1'b1;
                    r_cnt     <= '0;
                    r_state   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (pready || (r_cnt == TO_LAST)) begin
                        // Byte done: record data/error, then next lane or respond.
                        if (pready) begin
                            if (!r_write) begin
                                r_rsp_rdata[{r_lane, 3'b000} +: 8] <= prdata;
                            end
                            r_rsp_err <= r_rsp_err | pslverr;
                        end else begin
                            r_rsp_err <= 1'b1;
                        end
                        r_mask <= w_mask_rest;
                        if (w_pick_any) begin
                            r_lane    <= w_pick_lane;
                            r_penable <= 1'b0;
                            r_paddr   <= {r_base, w_pick_lane};
                            r_pwdata  <= r_wdata[{w_pick_lane, 3'b000} +: 8];
                            r_state   <= ST_SETUP;
                        end else begin
                            r_psel      <= 1'b0;
                            r_penable   <= 1'b0;
                            r_pwrite    <= 1'b0;
                            r_paddr     <= '0;
                            r_pwdata    <= '0;
                            r_rsp_valid <= 1'b1;
                            r_state     <= ST_RESP;
                        end
                    end else begin
                        r_cnt <= r_cnt + 10'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready = (r_state == ST_IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign psel      = r_psel;
    assign penable   = r_penable;
    assign pwrite    = r_pwrite;
    assign paddr     = r_paddr;
    assign pwdata    = r_pwdata;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_apb8_host_bridge.sv
// Bench for apb8_host_bridge with a small APB slave model and a response
// scoreboard.
module tb_apb8_host_bridge;

  localparam int ADDR_W = 32;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic [63:0]       req_wdata;
  logic [7:0]        req_wstrb;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [63:0]       rsp_rdata;
  logic              rsp_err;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [7:0]        pwdata;
  logic              pready;
  logic              pslverr;
  logic [7:0]        prdata;
  logic [1:0]        dbg_state;

  apb8_host_bridge #(.TIMEOUT_CYCLES(4), .ADDR_W(ADDR_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pready(pready), .pslverr(pslverr), .prdata(prdata), .dbg_state(dbg_state)
  );

  // ---------------- clock / cycle counter / watchdog ----------------
  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  initial begin
    #400000;
    $display("FAIL watchdog act=time_expired exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- APB slave model ----------------
  logic [7:0] slave_mem[8];
  logic [7:0] sl_err = '0;
  int         sl_wait = 0;
  int         sl_hang = 0;
  int         sl_cnt = 0;

  always @(negedge clk_i) begin
    if (psel && penable) sl_cnt = sl_cnt + 1;
    else sl_cnt = 0;
    pready  = psel && penable && (sl_hang == 0) && (sl_cnt > sl_wait);
    pslverr = pready && sl_err[paddr[2:0]];
    prdata  = (pready && !sl_err[paddr[2:0]]) ? slave_mem[paddr[2:0]] : 8'h00;
  end

  // ---------------- APB monitor ----------------
  typedef struct packed {
    logic        w;
    logic [31:0] a;
    logic [7:0]  d;
  } apb_t;
  apb_t apb_q[$];
  int   acc_run = 0;
  int   last_acc_len = 0;

  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (psel && !penable) apb_q.push_back({pwrite, paddr, pwdata});
      if (psel && penable) acc_run = acc_run + 1;
      else if (acc_run > 0) begin
        last_acc_len = acc_run;
        acc_run = 0;
      end
      if (!psel) chk("apb_idle_zero", 64'({penable, pwdata, paddr}), 64'd0);
    end else begin
      acc_run = 0;
    end
  end

  // ---------------- scoreboard / vectors ----------------
  logic [64:0] exp_q[$];

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic [7:0]  sl_err;
    logic [63:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_napb;
    logic [31:0] first_a;
    logic [7:0]  first_d;
    logic [31:0] last_a;
    logic [7:0]  last_d;
  } vec_t;

  function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [1:0] s,
                              input logic [63:0] wd, input logic [7:0] ws, input logic [7:0] se,
                              input logic [63:0] er, input logic ee, input int lat, input int n,
                              input logic [31:0] fa, input logic [7:0] fd,
                              input logic [31:0] la, input logic [7:0] ld);
    vec_t v;
    v.write = w; v.addr = a; v.size = s; v.wdata = wd; v.wstrb = ws; v.sl_err = se;
    v.exp_rdata = er; v.exp_err = ee; v.exp_lat = lat; v.exp_napb = n;
    v.first_a = fa; v.first_d = fd; v.last_a = la; v.last_d = ld;
    return v;
  endfunction

  // ---------------- driver ----------------
  task automatic run_vec(input vec_t v, input int hang, input int exp_acc_len);
    logic [64:0] e;
    logic [63:0] cap_d;
    logic        cap_e;
    int          t_acc;
    int          hold;
    logic        got;
    sl_err = v.sl_err;
    sl_hang = hang;
    sl_wait = 0;
    apb_q.delete();
    last_acc_len = 0;
    exp_q.push_back({v.exp_err, v.exp_rdata});
    @(negedge clk_i);
    chk("req_ready_idle", 64'(req_ready), 64'd1);
    t_acc = cyc;
    req_write = v.write; req_addr = v.addr; req_size = v.size;
    req_wdata = v.wdata; req_wstrb = v.wstrb; req_valid = 1'b1;
    @(negedge clk_i);
    req_valid = 1'b0;
    req_wdata = 64'($urandom) << 32 | 64'($urandom);
    chk("req_ready_busy", 64'(req_ready), 64'd0);
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (rsp_valid) begin
        got = 1'b1;
        break;
      end
      @(negedge clk_i);
    end
    chk("rsp_seen", 64'(got), 64'd1);
    e = exp_q.pop_front();
    if (!got) return;
    chk("latency", 64'(cyc - t_acc), 64'(v.exp_lat));
    chk("rsp_rdata", rsp_rdata, e[63:0]);
    chk("rsp_err", 64'(rsp_err), 64'(e[64]));
    cap_d = rsp_rdata;
    cap_e = rsp_err;
    hold = $urandom_range(0, 2);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk_i);
      chk("rsp_hold_valid", 64'(rsp_valid), 64'd1);
      chk("rsp_hold_data", {rsp_rdata[62:0], rsp_err} ^ {cap_d[62:0], cap_e}, 64'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk_i);
    rsp_ready = 1'b0;
    chk("rsp_drop", 64'(rsp_valid), 64'd0);
    chk("back_idle", 64'(req_ready), 64'd1);
    chk("apb_count", 64'(apb_q.size()), 64'(v.exp_napb));
    if (v.exp_napb > 0 && apb_q.size() > 0) begin
      chk("apb_first_addr", 64'(apb_q[0].a), 64'(v.first_a));
      chk("apb_last_addr", 64'(apb_q[apb_q.size()-1].a), 64'(v.last_a));
      chk("apb_pwrite", 64'(apb_q[0].w), 64'(v.write));
      if (v.write) begin
        chk("apb_first_data", 64'(apb_q[0].d), 64'(v.first_d));
        chk("apb_last_data", 64'(apb_q[apb_q.size()-1].d), 64'(v.last_d));
      end
    end
    if (exp_acc_len > 0) chk("access_len", 64'(last_acc_len), 64'(exp_acc_len));
  endtask

  // ---------------- main sequence ----------------
  vec_t vecs[10];
  vec_t tv;
  logic got_acc;
  logic seen_rsp;
  int   lane;

  initial begin
    rst_i = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_size = '0;
    req_wdata = '0; req_wstrb = '0; rsp_ready = 1'b0;
    pready = 1'b0; pslverr = 1'b0; prdata = '0;
    for (int i = 0; i < 8; i++) slave_mem[i] = 8'hC0 | 8'(i);
    slave_mem[3] = 8'h5A;

    repeat (2) @(negedge clk_i);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_outputs", 64'({rsp_valid, rsp_err, psel, penable, pwrite, pwdata, paddr}), 64'd0);
    chk("rst_rdata", rsp_rdata, 64'd0);
    chk("rst_state", 64'(dbg_state), 64'd0);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("post_rst_idle", 64'({req_ready, rsp_valid, psel}), 64'b100);

    // write, addr, size, wdata, wstrb, slverr, rdata, err, lat, napb, first a/d, last a/d
    vecs[0] = mk(0, 32'h8003, 2'd0, 64'h0, 8'h00, 8'h00, 64'h0000_0000_5A00_0000, 0, 3, 1,
                 32'h8003, 8'h00, 32'h8003, 8'h00);
    vecs[1] = mk(0, 32'h0000, 2'd3, 64'h0, 8'h00, 8'h00, 64'hC7C6_C5C4_5AC2_C1C0, 0, 17, 8,
                 32'h0000, 8'h00, 32'h0007, 8'h00);
    vecs[2] = mk(0, 32'h0006, 2'd2, 64'h0, 8'h00, 8'h00, 64'h0, 1, 1, 0,
                 32'h0, 8'h00, 32'h0, 8'h00);
    vecs[3] = mk(0, 32'h0004, 2'd2, 64'h0, 8'h00, 8'h00, 64'hC7C6_C5C4_0000_0000, 0, 9, 4,
                 32'h0004, 8'h00, 32'h0007, 8'h00);
    vecs[4] = mk(0, 32'h0102, 2'd1, 64'h0, 8'h00, 8'h04, 64'h0000_0000_5A00_0000, 1, 5, 2,
                 32'h0102, 8'h00, 32'h0103, 8'h00);
    vecs[5] = mk(1, 32'h0000, 2'd0, 64'h1122_3344_5566_7788, 8'h81, 8'h00, 64'h0, 0, 5, 2,
                 32'h0000, 8'h88, 32'h0007, 8'h11);
    vecs[6] = mk(1, 32'h0020, 2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 8'h00, 64'h0, 0, 1, 0,
                 32'h0, 8'h00, 32'h0, 8'h00);
    vecs[7] = mk(1, 32'hABCD0, 2'd0, 64'h0123_4567_89AB_CDEF, 8'h3C, 8'h00, 64'h0, 0, 9, 4,
                 32'hABCD2, 8'hAB, 32'hABCD5, 8'h45);
    vecs[8] = mk(0, 32'h0007, 2'd0, 64'h0, 8'h00, 8'h00, 64'hC700_0000_0000_0000, 0, 3, 1,
                 32'h0007, 8'h00, 32'h0007, 8'h00);
    vecs[9] = mk(0, 32'h0007, 2'd1, 64'h0, 8'h00, 8'h00, 64'h0, 1, 1, 0,
                 32'h0, 8'h00, 32'h0, 8'h00);

    for (int i = 0; i < 10; i++) run_vec(vecs[i], 0, 0);

    // Timeout: slave never ready, ACCESS must last exactly 4 cycles.
    tv = mk(0, 32'h0010, 2'd0, 64'h0, 8'h00, 8'h00, 64'h0, 1, 6, 1,
            32'h0010, 8'h00, 32'h0010, 8'h00);
    run_vec(tv, 1, 4);

    // Reset in the middle of a slow multi-byte write.
    sl_err = '0; sl_hang = 0; sl_wait = 3;
    @(negedge clk_i);
    req_write = 1'b1; req_addr = 32'h40; req_size = 2'd0;
    req_wdata = 64'hDEAD_BEEF_CAFE_F00D; req_wstrb = 8'hFF; req_valid = 1'b1;
    @(negedge clk_i);
    req_valid = 1'b0;
    got_acc = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (psel && penable) begin
        got_acc = 1'b1;
        break;
      end
      @(negedge clk_i);
    end
    chk("rst_reach_access", 64'(got_acc), 64'd1);
    rst_i = 1'b1;
    #1;
    chk("rst_mid_psel", 64'({psel, penable}), 64'd0);
    chk("rst_mid_bus", 64'({pwdata, paddr}), 64'd0);
    chk("rst_mid_ready", 64'({req_ready, rsp_valid}), 64'b10);
    @(negedge clk_i);
    rst_i = 1'b0;
    sl_wait = 0;
    seen_rsp = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      if (rsp_valid) seen_rsp = 1'b1;
    end
    chk("rst_no_rsp", 64'(seen_rsp), 64'd0);
    run_vec(vecs[0], 0, 0);

    // Random single-byte reads across lanes and base addresses.
    for (int k = 0; k < 6; k++) begin
      lane = $urandom_range(0, 7);
      tv = mk(0, (32'($urandom_range(0, 65535)) & ~32'h7) | 32'(lane), 2'd0, 64'h0, 8'h00, 8'h00,
              64'(slave_mem[lane]) << (8 * lane), 0, 3, 1, 32'h0, 8'h00, 32'h0, 8'h00);
      tv.first_a = tv.addr;
      tv.last_a = tv.addr;
      run_vec(tv, 0, 0);
    end

    repeat (2) @(negedge clk_i);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb8_host_bridge.md
APB8_HOST_BRIDGE -- requirements
Module: apb8_host_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: maximum ACCESS-phase cycles per byte before forced error (range 1..1023).
REQ-002 SHALL have parameter ADDR_W, default 32: width of host and APB addresses.
REQ-003 SHALL have a single clock and an asynchronous active-high reset.
REQ-004 clk_i  in  1  sole clock; host side and APB side both run on it.
REQ-005 rst_i  in  1  asynchronous, active-high reset.
REQ-006 req_valid  in  1  host request present.
REQ-007 req_ready  out  1  bridge accepts request this cycle.
REQ-008 req_write  in  1  1=write, 0=read.
REQ-009 req_addr  in  ADDR_W  byte address; [2:0] is the start lane.
REQ-010 req_size  in  2  read size: 0=1B, 1=2B, 2=4B, 3=8B.
REQ-011 req_wdata  in  64  write data, lane i = bits [8i+7:8i].
REQ-012 req_wstrb  in  8  write byte enables, one bit per lane.
REQ-013 rsp_valid  out  1  response present.
REQ-014 rsp_ready  in  1  host takes response.
REQ-015 rsp_rdata  out  64  read data, lane-aligned.
REQ-016 rsp_err  out  1  OR of all byte errors.
REQ-017 psel, penable, pwrite  out  1 each  APB master controls.
REQ-018 paddr  out  ADDR_W  APB address; pwdata  out  8  APB write byte.
REQ-019 pready, pslverr  in  1 each; prdata  in  8  APB slave response.

Function
REQ-020 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP.
REQ-021 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid && req_ready.
REQ-022 On acceptance, SHALL latch the request and build an 8-bit lane mask: for writes req_wstrb; for reads (2^req_size) consecutive lanes from req_addr[2:0].
REQ-023 A read whose lanes would exceed lane 7 SHALL go IDLE->RESP with rsp_err=1, rsp_rdata=0 and no APB transfer.
REQ-024 A write with req_wstrb=0 SHALL go IDLE->RESP with rsp_err=0 and no APB transfer.
REQ-025 Otherwise SHALL go to SETUP with the lowest set mask lane; SETUP drives psel=1, penable=0, paddr={req_addr[ADDR_W-1:3],lane}, pwdata=lane byte, pwrite=req_write, for exactly one cycle.
REQ-026 ACCESS SHALL drive psel=1, penable=1 with paddr/pwdata/pwrite unchanged, and hold until pready=1 or timeout.
REQ-027 On pready=1 in ACCESS: a read SHALL store prdata into rsp_rdata lane; pslverr SHALL be ORed into rsp_err; the lane SHALL be cleared from the mask.
REQ-028 Timeout: ACCESS cycle counter reaching TIMEOUT_CYCLES without pready SHALL end the byte as error (lane data 0), deassert psel/penable next cycle.
REQ-029 After a byte ends, SHALL go to SETUP if mask bits remain, else RESP; errors SHALL NOT abort remaining bytes.
REQ-030 RESP SHALL hold rsp_valid=1 and stable rsp_rdata/rsp_err until rsp_ready=1, then go IDLE.
REQ-031 Unaccessed read lanes and all write-response rsp_rdata SHALL be 0.
REQ-032 psel SHALL be 0 in IDLE and RESP; paddr/pwdata SHALL be 0 when psel=0.
REQ-033 Latency: 1-byte access with pready=1 in first ACCESS cycle: accept at T, SETUP T+1, ACCESS T+2, rsp_valid T+3; each extra byte adds 2 cycles.

Reset
REQ-034 rst_i SHALL force IDLE and zero all outputs except req_ready=1, including mid-transfer; no response is generated for the aborted request.

Structure
REQ-035 State enum and req_size encodings SHALL reside in shared package apb8_bridge_pkg.
REQ-036 Lowest-set-bit lane selection SHALL be sub-module apb8_lane_pick (8-bit mask in, 3-bit index and any-set flag out, combinational).

Verification
REQ-037 Read addr 0x8003 size 0, prdata=0x5A, pready immediate -> paddr=0x8003, rsp_rdata=0x0000_0000_5A00_0000 at T+3, rsp_err=0.
REQ-038 Write addr 0x0000, wstrb=0x81, wdata=0x11..88 -> two APB writes paddr 0x0000 pwdata 0x88, then 0x0007 pwdata 0x11; rsp_valid at T+5.
REQ-039 Read addr 0x0006 size 2 -> no psel, rsp_err=1 one cycle after accept.
REQ-040 Read size 1 with pslverr=1 on first byte only -> both bytes accessed, rsp_err=1, second byte data returned.
REQ-041 pready held 0, TIMEOUT_CYCLES=4 -> ACCESS lasts 4 cycles, psel drops, rsp_err=1.
REQ-042 rst_i asserted during ACCESS of multi-byte write -> psel=0 immediately, rsp_valid never asserts, next request serviced normally.
